// File: rtl/lsu_mem_responder.sv
// Word-array data memory behind a valid/ready bus for the core's load/store path.
// One request is served at a time; responses appear LATENCY+1 edges after accept.
module lsu_mem_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic               wen_q;
    logic               in_range_q;
    logic [IDX_W-1:0]   idx_q;
    logic [63:0]        wdata_q;
    logic [7:0]         wmask_q;
    logic [63:0]        offset;
    logic               do_access;
    logic [63:0]        mem [DEPTH];

    // Unsigned offset makes addresses below BASE_ADDR wrap to huge values and fail the range test.
    assign offset    = req_addr - BASE_ADDR;
    assign do_access = (state == WAIT) && (cnt == 4'd0);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wen_q      <= 1'b0;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
            rsp_rdata  <= 64'd0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wen_q      <= req_wen;
                        idx_q      <= offset[IDX_W+2:3];
                        wdata_q    <= req_wdata;
                        wmask_q    <= req_wmask;
                        in_range_q <= (offset < SPAN);
                        cnt        <= 4'(LATENCY);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= RESP;
                        rsp_err   <= ~in_range_q;
                        rsp_rdata <= (in_range_q && !wen_q) ? mem[idx_q] : 64'd0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array is deliberately not reset; an async reset clears state first, so a pending write never commits.
    always_ff @(posedge clk) begin
        if (do_access && wen_q && in_range_q) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: requests push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_lsu_mem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          LAT  = 2;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int   vec_count = 0;
    int   err_count = 0;
    exp_t exp_q[$];

    lsu_mem_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (1024),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: the handshake edge follows this negedge, so compare against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("stray response", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    task automatic sendRequest(input logic wen, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] wmask);
        int waited;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        waited    = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) checkOutput("accept timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = 64'hDEAD_BEEF_0000_0000;
        req_wdata = 64'h0;
        req_wmask = 8'h0;
    endtask

    task automatic waitResponse(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic applyStimulus(input logic wen, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] wmask,
                                 input logic [63:0] exp_rdata, input logic exp_err);
        int   edges;
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        sendRequest(wen, addr, wdata, wmask);
        waitResponse(edges);
        checkOutput("response latency", 64'(edges), 64'(LAT + 1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   edges;
        exp_t e;
        logic [63:0] held;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = 64'h0;
        req_wdata = 64'h0;
        req_wmask = 8'h0;
        rsp_ready = 1'b1;

        #12;
        checkOutput("reset req_ready", 64'(req_ready), 64'd1);
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 64'd0);
        checkOutput("reset rsp_err", 64'(rsp_err), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle rsp_valid", 64'(rsp_valid), 64'd0);
        end

        // Full write then readback
        applyStimulus(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b0);

        // Byte writes, addr[2:0] ignored, sparse mask, empty mask
        applyStimulus(1'b1, 64'h8000_0017, 64'hAB00_0000_0000_0000, 8'h80, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'hAB22_3344_5566_7788, 1'b0);
        applyStimulus(1'b1, 64'h8000_0010, 64'h0000_00CC_0000_00DD, 8'h11, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'hAB22_33CC_5566_77DD, 1'b0);
        applyStimulus(1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'hAB22_33CC_5566_77DD, 1'b0);

        // Backpressure on a read response with a competing request held high
        rsp_ready = 1'b0;
        e.rdata = 64'hAB22_33CC_5566_77DD;
        e.err   = 1'b0;
        exp_q.push_back(e);
        sendRequest(1'b0, 64'h8000_0010, 64'h0, 8'h00);
        waitResponse(edges);
        checkOutput("bp latency", 64'(edges), 64'(LAT + 1));
        held      = rsp_rdata;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 64'h8000_0010;
        req_wdata = 64'h0;
        req_wmask = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("bp rsp_rdata", rsp_rdata, 64'hAB22_33CC_5566_77DD);
            checkOutput("bp req_ready", 64'(req_ready), 64'd0);
        end
        checkOutput("bp rdata held", held, 64'hAB22_33CC_5566_77DD);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-hs rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("post-hs req_ready", 64'(req_ready), 64'd1);
        checkOutput("post-hs rdata hold", rsp_rdata, 64'hAB22_33CC_5566_77DD);
        @(posedge clk);
        #1;
        checkOutput("no bp accept", 64'(req_ready), 64'd1);
        applyStimulus(1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'hAB22_33CC_5566_77DD, 1'b0);

        // Out of range on both sides; aliasing write must not touch word 0
        applyStimulus(1'b1, 64'h8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 64'd0, 1'b1);
        applyStimulus(1'b0, 64'h8000_2000, 64'h0, 8'h00, 64'd0, 1'b1);
        applyStimulus(1'b1, 64'h8000_2000, 64'h1234_5678_9ABC_DEF0, 8'hFF, 64'd0, 1'b1);
        applyStimulus(1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        applyStimulus(1'b0, 64'h8000_1FF8, 64'h0, 8'h00, 64'h0, 1'b0);

        // Reset during WAIT drops the write and its response
        applyStimulus(1'b1, 64'h8000_0020, 64'h0, 8'hFF, 64'd0, 1'b0);
        sendRequest(1'b1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid-reset req_ready", 64'(req_ready), 64'd1);
        checkOutput("mid-reset rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post-reset rsp_valid", 64'(rsp_valid), 64'd0);
        end
        applyStimulus(1'b0, 64'h8000_0020, 64'h0, 8'h00, 64'd0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
